// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out serializer with a one-word hold buffer; even parity bit per frame when PISO_PARITY_EN is defined
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
`ifdef PISO_PARITY_EN
    localparam logic [1:0] PARITY = 2'd2;
    logic par;
`endif
    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] next_word;
    logic [CW-1:0]    bit_cnt;
    logic             hold_full;
    logic             accept;
    logic             last_bit;
    logic             frame_end;
    logic             take_next;
    logic             data_bit;

    // Handshake, frame boundaries and the outgoing bit, all decoded from the current state
    always_comb begin
        load_ready   = !hold_full && !reset;
        accept       = load_valid && load_ready;
        last_bit     = state == SHIFT && bit_cnt == CW'(WIDTH - 1);
        take_next    = hold_full || accept;
        next_word    = hold_full ? hold : in_data;
        shifted      = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
        serial_valid = state != IDLE;
        frame_start  = state == SHIFT && bit_cnt == '0;
`ifdef PISO_PARITY_EN
        frame_end    = state == PARITY;
        data_bit     = state == PARITY ? par : (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
`else
        frame_end    = last_bit;
        data_bit     = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
`endif
        frame_done   = frame_end;
        serial_out   = serial_valid && data_bit;
    end

    // Frame sequencing: at a frame boundary take the hold word (or a bypassed new word), otherwise shift and park incoming words in hold
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
`ifdef PISO_PARITY_EN
            par       <= 1'b0;
`endif
        end else if (state == IDLE || frame_end) begin
            bit_cnt <= '0;
            state   <= take_next ? SHIFT : IDLE;
            if (take_next) begin
                shreg     <= next_word;
                hold_full <= 1'b0;
`ifdef PISO_PARITY_EN
                par       <= ^next_word;
`endif
            end
        end else begin
            shreg   <= shifted;
            bit_cnt <= bit_cnt + CW'(1);
`ifdef PISO_PARITY_EN
            if (last_bit) state <= PARITY;
`endif
            if (accept) begin
                hold      <= in_data;
                hold_full <= 1'b1;
            end
        end
    end
endmodule
